// File: rtl/sc_bus_arb_if.sv
// Signal bundle between the two masters, the arbiter and the downstream sc_bus.
// A master raises *_req_i with stable fields and holds them until its one-cycle *_ack_o;
// keeping req high through the ack cycle is a new request, arbitrated in the next idle cycle.
interface sc_bus_arb_if;
  logic        m0_req_i;
  logic        m1_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m0_wdata_i;
  logic [31:0] m1_wdata_i;
  logic [3:0]  m0_be_i;
  logic [3:0]  m1_be_i;
  logic        m0_we_i;
  logic        m1_we_i;
  logic        m0_gnt_o;
  logic        m1_gnt_o;
  logic        m0_ack_o;
  logic        m1_ack_o;
  logic [31:0] m0_rdata_o;
  logic [31:0] m1_rdata_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        be0_o;
  logic        be1_o;
  logic        be2_o;
  logic        be3_o;
  logic        we_o;
  logic [31:0] rdata_i;
  logic        busy_o;

  modport slave (
    input  m0_req_i, m1_req_i, m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    input  m0_be_i, m1_be_i, m0_we_i, m1_we_i, rdata_i,
    output m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, m0_rdata_o, m1_rdata_o,
    output addr_o, wdata_o, be0_o, be1_o, be2_o, be3_o, we_o, busy_o
  );

  modport master (
    output m0_req_i, m1_req_i, m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i,
    output m0_be_i, m1_be_i, m0_we_i, m1_we_i, rdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, m0_rdata_o, m1_rdata_o,
    input  addr_o, wdata_o, be0_o, be1_o, be2_o, be3_o, we_o, busy_o
  );
endinterface

// File: rtl/sc_bus_arb.sv
// Round-robin two-master arbiter for sc_bus: latches the winner's access, holds it for
// WAIT_CYCLES bus cycles (legal 1..15), then returns the captured read data with a one-cycle ack.
module sc_bus_arb #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sc_bus_arb_if.slave   bus,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req;
  logic        winner;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      cnt_q   <= 4'd0;
      first_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Under contention the master that was not served last wins.
  assign any_req = bus.m0_req_i | bus.m1_req_i;
  assign winner  = (bus.m0_req_i & bus.m1_req_i) ? ~last_q : bus.m1_req_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          last_d  = winner;
          cnt_d   = CNT_INIT;
          first_d = 1'b1;
          addr_d  = winner ? bus.m1_addr_i  : bus.m0_addr_i;
          wdata_d = winner ? bus.m1_wdata_i : bus.m0_wdata_i;
          be_d    = winner ? bus.m1_be_i    : bus.m0_be_i;
          we_d    = winner ? bus.m1_we_i    : bus.m0_we_i;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        first_d = 1'b0;
        if (cnt_q == 4'd0) begin
          // Writes capture as well; the value is simply unused by the writer.
          rdata_d = bus.rdata_i;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Every output is a decode of registered state; nothing flows through from req or rdata_i.
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.m0_gnt_o   = (state_q != ST_IDLE) & ~sel_q;
  assign bus.m1_gnt_o   = (state_q != ST_IDLE) &  sel_q;
  assign bus.m0_ack_o   = (state_q == ST_ACK)  & ~sel_q;
  assign bus.m1_ack_o   = (state_q == ST_ACK)  &  sel_q;
  assign bus.we_o       = (state_q == ST_ACCESS) & first_q & we_q;
  assign bus.addr_o     = addr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.be0_o      = be_q[0];
  assign bus.be1_o      = be_q[1];
  assign bus.be2_o      = be_q[2];
  assign bus.be3_o      = be_q[3];
  assign bus.m0_rdata_o = rdata_q;
  assign bus.m1_rdata_o = rdata_q;
  assign dbg_state_o    = state_q;

endmodule
